booth_mul_8bit: RTL and testbench

//   Sequential signed 8x8 radix-2 Booth multiplier producing a 16-bit product.

---
 rtl/booth_mul_8bit.sv | 155 +++++++++++++++
 tb/tb_booth_mul_8bit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_8bit.sv
// Signed 8x8 radix-2 Booth multiplier around a ripple add/sub stage.
// Optional BOOTH_EARLY_TERM_EN: finishes early with a barrel shift once the remaining multiplier bits are uniform.

// Purpose: 8-bit ripple-carry adder/subtractor (a+b or a-b) with signed overflow.
// Latency: combinational.
// Backpressure: none.
module ripple_addsub_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       addsub,
   output logic [7:0] sum,
   output logic       overflow
);
   logic [8:0] carry;
   logic [7:0] b_x;

   assign b_x      = b ^ {8{addsub}};
   assign carry[0] = addsub;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign sum[i]     = a[i] ^ b_x[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
   end

   assign overflow = carry[8] ^ carry[7];
endmodule

// Purpose: sequential signed 8x8 Booth multiplier, 16-bit exact product.
// Latency: out_valid 9 edges after acceptance (fewer with early termination).
// Backpressure: product held in DONE until out_ready; in_ready low while busy.
module booth_mul_8bit (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_product,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     state;
   logic [7:0] m_reg;
   logic [7:0] a_reg;
   logic [7:0] q_reg;
   logic       q_m1;
   logic [3:0] count;

   logic       addsub;
   logic       do_arith;
   logic [7:0] sum;
   logic       overflow;
   logic [8:0] a_ext;
   logic [7:0] a_sh;
   logic [7:0] q_sh;
   logic       qm1_sh;
   logic [3:0] count_dec;

   ripple_addsub_8bit u_addsub (
      .a        (a_reg),
      .b        (m_reg),
      .addsub   (addsub),
      .sum      (sum),
      .overflow (overflow)
   );

   // The true 9-bit sign of A+/-M is sum[7]^overflow; this keeps M=-128 exact.
   always_comb begin
      addsub    = q_reg[0] & ~q_m1;
      do_arith  = q_reg[0] ^ q_m1;
      a_ext     = do_arith ? {sum[7] ^ overflow, sum} : {a_reg[7], a_reg};
      a_sh      = a_ext[8:1];
      q_sh      = {a_ext[0], q_reg[7:1]};
      qm1_sh    = q_reg[0];
      count_dec = count - 4'd1;
   end

`ifdef BOOTH_EARLY_TERM_EN
   logic [8:0]         rem_bits;
   logic [8:0]         rem_mask;
   logic               early;
   logic signed [15:0] prod_sh;
   logic signed [15:0] prod_bar;

   // Unexamined multiplier bits plus q_m1 all equal means only shifts remain.
   always_comb begin
      rem_bits = {q_sh, qm1_sh};
      rem_mask = (9'd2 << count_dec) - 9'd1;
      early    = (count_dec != 4'd0) &&
                 (((rem_bits & rem_mask) == 9'd0) || ((rem_bits & rem_mask) == rem_mask));
      prod_sh  = {a_sh, q_sh};
      prod_bar = prod_sh >>> count_dec;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         out_product <= 16'd0;
         busy        <= 1'b0;
         m_reg       <= 8'd0;
         a_reg       <= 8'd0;
         q_reg       <= 8'd0;
         q_m1        <= 1'b0;
         count       <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  m_reg    <= in_a;
                  q_reg    <= in_b;
                  a_reg    <= 8'd0;
                  q_m1     <= 1'b0;
                  count    <= 4'd8;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (count == 4'd0) begin
                  out_product <= {a_reg, q_reg};
                  out_valid   <= 1'b1;
                  state       <= DONE;
               end else begin
                  a_reg <= a_sh;
                  q_reg <= q_sh;
                  q_m1  <= qm1_sh;
                  count <= count_dec;
`ifdef BOOTH_EARLY_TERM_EN
                  if (early) begin
                     {a_reg, q_reg} <= prod_bar;
                     count          <= 4'd0;
                  end
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_mul_8bit.sv
// Bench for booth_mul_8bit: arithmetic/latency model plus directed literal cases and random traffic.
module tb_booth_mul_8bit;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_product;
   logic        busy;

   always #5 clk = ~clk;

   booth_mul_8bit dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .busy        (busy)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Edges from acceptance to out_valid, from the multiplier bits alone.
   function automatic int model_lat(input logic [7:0] b);
`ifdef BOOTH_EARLY_TERM_EN
      for (int k = 1; k <= 7; k++) begin
         bit all0 = 1'b1;
         bit all1 = 1'b1;
         for (int i = k - 1; i <= 7; i++) begin
            if (b[i]) all0 = 1'b0;
            else      all1 = 1'b0;
         end
         if (all0 || all1) return k + 1;
      end
`endif
      return 9;
   endfunction

   // Transaction-level model: one pending op, its product and its due cycle.
   int          cyc     = 0;
   bit          pend    = 1'b0;
   int          acc_cyc = 0;
   int          lat     = 9;
   int          n_acc   = 0;
   logic [15:0] exp_prod = 16'd0;
   bit          checking = 1'b0;

   always @(posedge clk) begin
      bit hs;
      logic signed [15:0] p;
      hs = pend && (cyc - acc_cyc >= lat) && out_ready;
      cyc++;
      if (rst) begin
         pend = 1'b0;
      end else if (!pend) begin
         if (in_valid) begin
            pend     = 1'b1;
            acc_cyc  = cyc;
            p        = $signed(in_a) * $signed(in_b);
            exp_prod = p;
            lat      = model_lat(in_b);
            n_acc++;
         end
      end else if (hs) begin
         pend = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         bit ev;
         ev = pend && (cyc - acc_cyc >= lat);
         check("out_valid", out_valid, ev);
         check("in_ready", in_ready, !pend);
         check("busy", busy, pend);
         if (ev) check("out_product", out_product, exp_prod);
      end
   end

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                         output logic [15:0] prod, output int k);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b1; in_a = a; in_b = b; out_ready = 1'b0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         k++;
         @(negedge clk);
      end
      check("latency", k, model_lat(b));
      prod = out_product;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1 in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
         @(negedge clk);
         check("hold_in_ready", in_ready, 0);
         check("hold_valid", out_valid, 1);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   function automatic logic [7:0] pick();
      int r;
      r = int'($urandom % 8);
      case (r)
         0:       return 8'h80;
         1:       return 8'h7F;
         2:       return 8'h00;
         3:       return 8'hFF;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      logic [15:0] prod;
      int          k;
      int          w;
      int          target;
      int          guard;
      bit          seen_vld;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 8'd0; in_b = 8'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_product", out_product, 16'h0000);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      checking = 1'b1;

      run_op(8'd3, 8'hFC, 0, prod, k);
      check("p_3x-4", prod, 16'hFFF4);
`ifndef BOOTH_EARLY_TERM_EN
      check("lat_3x-4", k, 9);
`endif
      run_op(8'h80, 8'h80, 0, prod, k);
      check("p_-128x-128", prod, 16'h4000);
      run_op(8'h7F, 8'h80, 5, prod, k);
      check("p_127x-128", prod, 16'hC080);

      // Abort mid-run: reset sampled at acceptance+4.
      @(posedge clk);
      #1 in_valid = 1'b1; in_a = 8'd5; in_b = 8'd7;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      seen_vld = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen_vld = 1'b1;
      end
      check("rst_abort_no_valid", seen_vld, 0);
      check("rst_abort_in_ready", in_ready, 1);
      run_op(8'd2, 8'd3, 0, prod, k);
      check("p_2x3", prod, 16'h0006);

`ifdef BOOTH_EARLY_TERM_EN
      run_op(8'd5, 8'd0, 0, prod, k);
      check("et_b0_lat", k, 2);
      check("et_b0_prod", prod, 16'h0000);
      run_op(8'hF9, 8'd1, 0, prod, k);
      check("et_b1_fast", (k < 9), 1);
      check("et_b1_prod", prod, 16'hFFF9);
`endif

      // Back-to-back: in_valid held with out_ready=1.
      @(posedge clk);
      #1 in_valid = 1'b1; in_a = 8'd9; in_b = 8'hFD; out_ready = 1'b1;
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 20) begin
         w++;
         @(negedge clk);
      end
      check("b2b_first", out_product, 16'hFFE5);
      @(negedge clk);
      check("b2b_idle_after_hs", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("b2b_second_busy", busy, 1);
      w = 0;
      while (!out_valid && w < 20) begin
         w++;
         @(negedge clk);
      end
      check("b2b_second", out_product, 16'hFFE5);
      @(posedge clk);
      #1 out_ready = 1'b0;

      // Random traffic with random backpressure.
      target = n_acc + 1000;
      guard  = 0;
      while (n_acc < target && guard < 40000) begin
         @(posedge clk);
         #1;
         in_valid  = 1'($urandom % 2);
         in_a      = pick();
         in_b      = pick();
         out_ready = 1'($urandom % 2);
         guard++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("drain_idle", in_ready, 1);
      checking = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
